// File: rtl/acs_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// acs_sched : path-metric / ACS sequencing controller for the Viterbi decoder
// Revision  : 1.0
// ---------------------------------------------------------------------------
module acs_sched #(
  parameter int K         = 5,
  parameter int M         = K - 1,
  parameter int S         = 1 << M,
  parameter int SW        = 2,
  parameter int ACS_LAT   = 1,
  parameter int FRAME_LEN = 64,
  parameter int TW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          sym_valid,
  input  logic [SW-1:0] sym_data,
  output logic          sym_ready,
  output logic [SW-1:0] sym_q,
  output logic          init_frame,
  output logic          swap_banks,
  output logic [M-1:0]  rd_idx0,
  output logic [M-1:0]  rd_idx1,
  output logic          acs_valid,
  output logic          wr_en,
  output logic [M-1:0]  wr_idx,
  output logic [TW-1:0] step_idx,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [M-1:0]  S_LAST    = M'(S - 1);
  localparam logic [M-1:0]  S_HALF    = M'(S / 2);
  localparam logic [M-1:0]  S_ONE     = M'(1);
  localparam logic [TW-1:0] STEP_LAST = TW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] STEP_ONE  = TW'(1);

  logic [2:0]    state_q, state_d;
  logic [M-1:0]  s_q, s_d;
  logic [TW-1:0] step_q, step_d;
  logic [SW-1:0] symbol_q, symbol_d;
  logic          issue;
  logic          last_wr;

  assign issue      = (state_q == ST_ISSUE);
  assign acs_valid  = issue;
  assign sym_ready  = (state_q == ST_WAIT);
  assign busy       = (state_q != ST_IDLE);
  assign rd_idx0    = issue ? (s_q >> 1) : '0;
  assign rd_idx1    = issue ? ((s_q >> 1) | S_HALF) : '0;
  assign step_idx   = step_q;
  assign sym_q      = symbol_q;
  // The final write of a symbol is the single event that closes it out.
  assign last_wr    = wr_en && (wr_idx == S_LAST);

  generate
    if (ACS_LAT == 0) begin : g_lat_zero
      assign wr_en  = issue;
      assign wr_idx = s_q;
    end else begin : g_lat_pipe
      logic [ACS_LAT-1:0] pv_q, pv_d;
      logic [M-1:0]       ps_q [ACS_LAT];
      logic [M-1:0]       ps_d [ACS_LAT];

      always_comb begin
        pv_d[0] = issue;
        ps_d[0] = s_q;
        for (int i = 1; i < ACS_LAT; i++) begin
          pv_d[i] = pv_q[i-1];
          ps_d[i] = ps_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv_q <= '0;
          for (int i = 0; i < ACS_LAT; i++) begin
            ps_q[i] <= '0;
          end
        end else begin
          pv_q <= pv_d;
          for (int i = 0; i < ACS_LAT; i++) begin
            ps_q[i] <= ps_d[i];
          end
        end
      end

      assign wr_en  = pv_q[ACS_LAT-1];
      assign wr_idx = ps_q[ACS_LAT-1];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    step_d     = step_q;
    symbol_d   = symbol_q;
    init_frame = 1'b0;
    swap_banks = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          step_d  = '0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        init_frame = 1'b1;
        swap_banks = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (sym_valid) begin
          symbol_d = sym_data;
          s_d      = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        s_d = s_q + S_ONE;
        if (s_q == S_LAST) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Zero-latency builds complete from ISSUE; others from the last DRAIN cycle.
    if (last_wr) begin
      swap_banks = 1'b1;
      if (step_q == STEP_LAST) begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end else begin
        step_d  = step_q + STEP_ONE;
        state_d = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      step_q   <= '0;
      symbol_q <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      step_q   <= step_d;
      symbol_q <= symbol_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acs_sched.sv
`default_nettype none
// Testbench for acs_sched: three builds (ACS_LAT 1/0/4) checked against a
// timing-level model that counts cycles since each symbol accept.
module tb_acs_sched;

  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_data = 2'b00;

  logic       rdy_v [3];
  logic       init_v [3];
  logic       swap_v [3];
  logic       acs_v [3];
  logic       wren_v [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic [3:0] wr_idx_v [3];
  logic [3:0] rd0_v [3];
  logic [3:0] rd1_v [3];
  logic [7:0] step_v [3];
  logic [1:0] symq_v [3];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int         m_mode [3];
  int         m_k [3];
  int         m_step [3];
  logic [1:0] m_sym [3];

  acs_sched #(.ACS_LAT(1), .FRAME_LEN(4)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sym_valid(sym_valid),
    .sym_data(sym_data), .sym_ready(rdy_v[0]), .sym_q(symq_v[0]),
    .init_frame(init_v[0]), .swap_banks(swap_v[0]), .rd_idx0(rd0_v[0]),
    .rd_idx1(rd1_v[0]), .acs_valid(acs_v[0]), .wr_en(wren_v[0]),
    .wr_idx(wr_idx_v[0]), .step_idx(step_v[0]), .busy(busy_v[0]),
    .frame_done(done_v[0])
  );

  acs_sched #(.ACS_LAT(0), .FRAME_LEN(3)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sym_valid(sym_valid),
    .sym_data(sym_data), .sym_ready(rdy_v[1]), .sym_q(symq_v[1]),
    .init_frame(init_v[1]), .swap_banks(swap_v[1]), .rd_idx0(rd0_v[1]),
    .rd_idx1(rd1_v[1]), .acs_valid(acs_v[1]), .wr_en(wren_v[1]),
    .wr_idx(wr_idx_v[1]), .step_idx(step_v[1]), .busy(busy_v[1]),
    .frame_done(done_v[1])
  );

  acs_sched #(.ACS_LAT(4), .FRAME_LEN(3)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sym_valid(sym_valid),
    .sym_data(sym_data), .sym_ready(rdy_v[2]), .sym_q(symq_v[2]),
    .init_frame(init_v[2]), .swap_banks(swap_v[2]), .rd_idx0(rd0_v[2]),
    .rd_idx1(rd1_v[2]), .acs_valid(acs_v[2]), .wr_en(wren_v[2]),
    .wr_idx(wr_idx_v[2]), .step_idx(step_v[2]), .busy(busy_v[2]),
    .frame_done(done_v[2])
  );

  // wr_idx is only meaningful while wr_en is high.
  logic [28:0] obs [3];
  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {busy_v[g], rdy_v[g], init_v[g], swap_v[g], done_v[g], acs_v[g],
                     wren_v[g], (wren_v[g] ? wr_idx_v[g] : 4'd0), rd0_v[g], rd1_v[g],
                     step_v[g], symq_v[g]};
  end

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 4);
  endfunction

  function automatic int fl_of(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: mode 0 idle, 1 init, 2 wait, 3 processing (k = cycles since accept).
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_mode[i] <= 0;
        m_k[i]    <= 0;
        m_step[i] <= 0;
        m_sym[i]  <= 2'b00;
      end else begin
        case (m_mode[i])
          0: if (frame_start) begin m_mode[i] <= 1; m_step[i] <= 0; end
          1: m_mode[i] <= 2;
          2: if (sym_valid) begin m_mode[i] <= 3; m_k[i] <= 1; m_sym[i] <= sym_data; end
          default: begin
            if (m_k[i] == S + lat_of(i)) begin
              if (m_step[i] == fl_of(i) - 1) m_mode[i] <= 0;
              else begin m_mode[i] <= 2; m_step[i] <= m_step[i] + 1; end
            end else begin
              m_k[i] <= m_k[i] + 1;
            end
          end
        endcase
      end
    end
  end

  function automatic logic [28:0] model_out(int i);
    int k, lat;
    logic bsy, rdy, ini, sw, dn, av, we, last;
    logic [3:0] wi, r0, r1;
    if (!rst_n) return 29'd0;
    k    = m_k[i];
    lat  = lat_of(i);
    bsy  = (m_mode[i] != 0);
    rdy  = (m_mode[i] == 2);
    ini  = (m_mode[i] == 1);
    last = (m_mode[i] == 3) && (k == S + lat);
    sw   = ini || last;
    dn   = last && (m_step[i] == fl_of(i) - 1);
    av   = (m_mode[i] == 3) && (k <= S);
    we   = (m_mode[i] == 3) && (k > lat);
    r0   = av ? 4'((k - 1) / 2) : 4'd0;
    r1   = av ? 4'((k - 1) / 2 + S / 2) : 4'd0;
    wi   = we ? 4'(k - 1 - lat) : 4'd0;
    return {bsy, rdy, ini, sw, dn, av, we, wi, r0, r1, 8'(m_step[i]), m_sym[i]};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; frame_start = 1'b0; sym_valid = 1'b0; sym_data = 2'b00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== 29'd0 || wr_idx_v[i] !== 4'd0) begin
        n_fail++; $display("FAIL reset_hold inst%0d got=%h exp=0", i, obs[i]);
      end
    end
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs[i] !== model_out(i) || busy_v[i] !== 1'b0) begin
          n_fail++; $display("FAIL idle inst%0d t=%0d got=%h exp=%h", i, cyc, obs[i], model_out(i));
        end
      end
    end
  endtask

  task automatic test_frame_start;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (init_v[i] !== 1'b1 || swap_v[i] !== 1'b1 || rdy_v[i] !== 1'b0 || obs[i] !== model_out(i)) begin
        n_fail++; $display("FAIL init_cycle inst%0d got=%h exp=%h", i, obs[i], model_out(i));
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (init_v[i] !== 1'b0 || swap_v[i] !== 1'b0 || rdy_v[i] !== 1'b1 || obs[i] !== model_out(i)) begin
        n_fail++; $display("FAIL wait_ready inst%0d got=%h exp=%h", i, obs[i], model_out(i));
      end
    end
  endtask

  task automatic test_single_symbol;
    int nacs;
    nacs = 0;
    sym_valid = 1'b1; sym_data = 2'b10;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      sym_valid = 1'b0;
      sym_data  = 2'($urandom);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs[i] !== model_out(i)) begin
          n_fail++; $display("FAIL single_seq inst%0d t=%0d got=%h exp=%h", i, cyc, obs[i], model_out(i));
        end
      end
      if (acs_v[0]) nacs++;
      n_chk++;
      if (symq_v[0] !== 2'b10) begin
        n_fail++; $display("FAIL sym_q_hold got=%b exp=10", symq_v[0]);
      end
      n_chk++;
      if (swap_v[0] !== (wren_v[0] && wr_idx_v[0] == 4'd15)) begin
        n_fail++; $display("FAIL swap_on_last t=%0d swap=%b wr_en=%b wr_idx=%0d", cyc, swap_v[0], wren_v[0], wr_idx_v[0]);
      end
    end
    n_chk++;
    if (nacs != 16) begin
      n_fail++; $display("FAIL acs_count got=%0d exp=16", nacs);
    end
  endtask

  task automatic test_back_to_back;
    int prev [3];
    int nacc [3];
    int ndone [3];
    for (int i = 0; i < 3; i++) begin prev[i] = 0; nacc[i] = 0; ndone[i] = 0; end
    sym_valid = 1'b1;
    sym_data  = 2'($urandom);
    for (int n = 0; n < 70; n++) begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs[i] !== model_out(i)) begin
          n_fail++; $display("FAIL b2b inst%0d t=%0d got=%h exp=%h", i, cyc, obs[i], model_out(i));
        end
        if (sym_valid && rdy_v[i]) begin
          if (nacc[i] > 0) begin
            n_chk++;
            if (cyc - prev[i] != S + lat_of(i) + 1) begin
              n_fail++; $display("FAIL b2b_period inst%0d got=%0d exp=%0d", i, cyc - prev[i], S + lat_of(i) + 1);
            end
          end
          prev[i] = cyc;
          nacc[i]++;
        end
        if (done_v[i]) begin
          ndone[i]++;
          n_chk++;
          if (swap_v[i] !== 1'b1 || step_v[i] !== 8'(fl_of(i) - 1)) begin
            n_fail++; $display("FAIL done_with_swap inst%0d swap=%b step=%0d", i, swap_v[i], step_v[i]);
          end
        end
      end
      @(negedge clk);
      sym_data = 2'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (nacc[i] != fl_of(i) - 1 || ndone[i] != 1 || busy_v[i] !== 1'b0 || rdy_v[i] !== 1'b0) begin
        n_fail++; $display("FAIL b2b_count inst%0d accepts=%0d exp=%0d done=%0d busy=%b", i, nacc[i], fl_of(i) - 1, ndone[i], busy_v[i]);
      end
    end
    sym_valid = 1'b0;
  endtask

  task automatic test_stall_and_busy_start;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (acs_v[i] !== 1'b0 || wren_v[i] !== 1'b0 || init_v[i] !== 1'b0 ||
            swap_v[i] !== 1'b0 || rdy_v[i] !== 1'b1 || obs[i] !== model_out(i)) begin
          n_fail++; $display("FAIL stall inst%0d t=%0d got=%h exp=%h", i, cyc, obs[i], model_out(i));
        end
      end
    end
    sym_valid = 1'b1; sym_data = 2'b01;
    @(negedge clk);
    sym_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      frame_start = (n == 4);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (init_v[i] !== 1'b0 || obs[i] !== model_out(i)) begin
          n_fail++; $display("FAIL busy_start_ignored inst%0d t=%0d got=%h exp=%h", i, cyc, obs[i], model_out(i));
        end
      end
    end
    frame_start = 1'b0;
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      sym_valid   = ($urandom % 4) != 0;
      sym_data    = 2'($urandom);
      frame_start = ($urandom % 16) == 0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs[i] !== model_out(i)) begin
          n_fail++; $display("FAIL random inst%0d t=%0d got=%h exp=%h", i, cyc, obs[i], model_out(i));
        end
      end
    end
    sym_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic test_reset_mid_issue;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    sym_valid = 1'b1; sym_data = 2'b11;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      sym_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs[i] !== model_out(i)) begin
          n_fail++; $display("FAIL pre_reset inst%0d t=%0d got=%h exp=%h", i, cyc, obs[i], model_out(i));
        end
      end
    end
    n_chk++;
    if (rd0_v[0] !== 4'd3 || rd1_v[0] !== 4'd11 || acs_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL at_s7 rd0=%0d rd1=%0d acs=%b exp 3/11/1", rd0_v[0], rd1_v[0], acs_v[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== 29'd0 || wr_idx_v[i] !== 4'd0) begin
        n_fail++; $display("FAIL async_reset inst%0d got=%h exp=0", i, obs[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (wren_v[i] !== 1'b0 || swap_v[i] !== 1'b0 || init_v[i] !== 1'b0 ||
            busy_v[i] !== 1'b0 || obs[i] !== model_out(i)) begin
          n_fail++; $display("FAIL post_reset_quiet inst%0d t=%0d got=%h exp=%h", i, cyc, obs[i], model_out(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_single_symbol();
    test_back_to_back();
    test_stall_and_busy_start();
    test_random();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout t=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/acs_sched.md
# acs_sched

Sequencing controller for the path-metric bank and the add-compare-select (ACS) unit of the Viterbi decoder. For each frame it initialises the metrics once. For each accepted channel symbol it then steps through all S trellis states: it issues predecessor read indices to the bank, flags valid operands to the ACS unit, writes results back after a fixed ACS latency, and flips the ping-pong banks after the last write. It sits between the symbol input stream (valid/ready) and the metric bank / ACS / survivor-memory write port.

## Interface
- K, 5, constraint length
- M, K-1, state-index width
- S, 1<<M, number of trellis states
- SW, 2, width of one channel symbol (soft/hard bits, opaque here)
- ACS_LAT, 1, ACS pipeline depth in cycles from operand read to result valid; legal range 0..4
- FRAME_LEN, 64, symbols per frame; must be at least 1
- TW, 8, width of the step counter; requires FRAME_LEN ≤ 2^TW

Ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- sym_valid  in  1  symbol available
- sym_data  in  SW  channel symbol
- sym_ready  out  1  controller can accept a symbol
- sym_q  out  SW  latched symbol for the branch-metric unit; stable from accept through the symbol's swap cycle
- init_frame  out  1  to bank: reload initial metrics into the write bank
- swap_banks  out  1  to bank: flip ping-pong
- rd_idx0  out  M  predecessor 0 = s>>1
- rd_idx1  out  M  predecessor 1 = (s>>1) | S/2
- acs_valid  out  1  operands on rd_pm0/rd_pm1 are valid this cycle
- wr_en  out  1  to bank and survivor memory: write result
- wr_idx  out  M  destination state for wr_en
- step_idx  out  TW  index of the symbol being processed (0..FRAME_LEN-1)
- busy  out  1  high in every state other than IDLE
- frame_done  out  1  one-cycle pulse when the frame's last bank swap issues

## Operation
- State convention: next state ns = ((s<<1)|b) mod S. Predecessors of destination s are s>>1 and (s>>1)|S/2. The decision bit from the ACS unit selects between them; it is not handled here.
- IDLE: all strobes 0, sym_ready 0. On frame_start, clear step_idx and go to INIT.
- INIT (1 cycle): assert init_frame=1 and swap_banks=1 together, so the initialised bank becomes the read bank. Go to WAIT.
- WAIT: sym_ready=1. On sym_valid && sym_ready, latch sym_q, reset the state counter s to 0, and go to ISSUE.
- ISSUE (exactly S cycles):
  - Each cycle: acs_valid=1, rd_idx0 and rd_idx1 derived from the current s, then s increments.
  - s wraps only by leaving the state after s=S-1.
  - If ACS_LAT=0, leave through the completion step below; otherwise go to DRAIN.
- DRAIN (ACS_LAT cycles): acs_valid=0; the write pipeline empties.
- Write pipeline: an ACS_LAT-deep shift register of (valid, s). wr_en and wr_idx are its output; with ACS_LAT=0 they equal acs_valid and s combinationally.
- Completion step, taken on the cycle of the final write (s=S-1):
  - Assert swap_banks. The bank commits that write to the old write bank and flips on the same edge.
  - If step_idx==FRAME_LEN-1: pulse frame_done and go to IDLE.
  - Otherwise increment step_idx and go to WAIT.
- rd_idx0/rd_idx1 outside ISSUE: hold 0.
- frame_start outside IDLE: ignored; no queueing.
- sym_valid outside WAIT: not accepted; sym_ready is 0 there.

## Timing
- Reset (async assert, sync deassert is the integrator's job): state=IDLE, s=0, step_idx=0, sym_q=0, write pipeline cleared. All outputs are 0: sym_ready, init_frame, swap_banks, acs_valid, wr_en, wr_idx, rd_idx0, rd_idx1, busy, frame_done.
- Reset mid-frame: same as above. No swap or init is issued, and there are no partial writes after rst_n falls.
- Accept edge T: ISSUE occupies T+1..T+S. Write for s lands at cycle T+1+s+ACS_LAT. swap_banks and the last wr_en fall in cycle T+S+ACS_LAT.
- The earliest next accept is the next cycle, so the minimum symbol period is S+ACS_LAT+1 cycles.
- frame_start at edge F: INIT in F+1, sym_ready first high in F+2.
- One wr_en per destination state per symbol, in ascending wr_idx order, with no gaps inside ISSUE.
- swap_banks never asserts in the same cycle as init_frame, except in INIT.

## Test plan
- Reset/idle (K=5, ACS_LAT=1, FRAME_LEN=4): hold rst_n=0, then release with no stimulus → all outputs 0, busy=0 indefinitely. Pulse frame_start → init_frame=swap_banks=1 for exactly one cycle, then sym_ready=1.
- Single-symbol sequencing: accept a symbol with sym_data=2'b10 → 16 acs_valid cycles with rd_idx0 sequence 0,0,1,1,…,7,7 and rd_idx1 sequence 8,8,9,9,…,15,15; wr_idx 0..15 each delayed by 1 cycle; swap_banks coincides with wr_idx=15; sym_q=2'b10 throughout.
- Full frame with back-to-back sym_valid=1 → exactly 4 symbols accepted at 18-cycle spacing, step_idx 0..3, frame_done one cycle alongside the 4th swap, then IDLE with sym_ready=0.
- Stalled input: drop sym_valid for 10 cycles in WAIT → no acs_valid and no wr_en, bank strobes stay 0, and the next accept proceeds normally.
- ACS_LAT=0 and ACS_LAT=4 builds → wr_en same cycle as acs_valid / 4 cycles later respectively; swap on the final write; symbol periods of 17 and 21 cycles.
- Async reset in mid-ISSUE at s=7, plus frame_start while busy → outputs 0 immediately with no later wr_en or swap; a frame_start while busy is ignored and causes no second INIT.
